// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and types for the FPU issue/writeback slice.
//   NUM_UNITS    number of arithmetic units attached to the issue controller
//   unit_e       unit index (FADD..FABS), also the bit position in a one-hot op
//   LAT_DEFAULT  per-unit latency in cycles, indexed by unit_e
//   MAX_LAT      largest entry of LAT_DEFAULT; depth of the reservation register
//   rsv_entry_t  reservation slot {valid, unit, tag}
//   result_t     writeback record {y, tag, unit, ovf, unf}
package fpu_pkg;

  localparam int NUM_UNITS = 8;
  localparam int WIDTH     = 32;
  localparam int TAG_W     = 5;
  localparam int MAX_LAT   = 6;
  localparam int UNIT_W    = $clog2(NUM_UNITS);

  typedef enum logic [UNIT_W-1:0] {
    FADD, FSUB, FMUL, FDIV, FSQRT, FTOI, ITOF, FABS
  } unit_e;

  localparam int LAT_DEFAULT [NUM_UNITS] = '{3, 3, 3, 6, 3, 1, 2, 1};

  typedef struct packed {
    logic              valid;
    logic [UNIT_W-1:0] unit;
    logic [TAG_W-1:0]  tag;
  } rsv_entry_t;

  typedef struct packed {
    logic [WIDTH-1:0]  y;
    logic [TAG_W-1:0]  tag;
    logic [UNIT_W-1:0] unit;
    logic              ovf;
    logic              unf;
  } result_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: ordered result buffer with registered head.
//   clk, rstn  clock, synchronous active-low reset
//   push       write data into the tail this cycle
//   data       entry to write
//   ready      consumer takes the head when valid is high
//   valid      head holds an entry
//   head       oldest entry (entry 0 of a shift-down array)
//   count      number of stored entries
// Push and pop may happen together in any state, including full: the pop
// frees the last slot in the same edge that the push fills it.
module fpu_result_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  data,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem   [DEPTH];
  logic [W-1:0]  mem_n [DEPTH];
  logic [CW-1:0] count_n;
  logic [CW-1:0] wr;
  logic          pop;

  assign pop  = valid && ready;
  assign head = mem[0];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_n[i] = mem[i];
    count_n = count;
    wr      = count;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i + 1];
      mem_n[DEPTH-1] = '0;
      wr = count - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr) mem_n[i] = data;
      end
    end
    if (push && !pop) count_n = count + CW'(1);
    if (!push && pop) count_n = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
      count <= count_n;
      valid <= (count_n != '0);
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/writeback controller for the FPU cluster.
//   mem_clk, rstn       clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; in_op one-hot unit, in_tag tag
//   unit_start          one-cycle start strobe to the selected unit
//   unit_y/ovf/unf      unit results and flags, unit u at [u*WIDTH +: WIDTH]
//   out_valid/out_ready result handshake; out_y/tag/unit/ovf/unf payload
//   err_illegal         pulse the cycle after a non-one-hot op was consumed
//   busy                operations in flight or results buffered
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; valid does not wait for ready, and in_ready depends only on
// registered state, rstn and in_op (never on out_ready).
module fpu_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = fpu_pkg::NUM_UNITS,
  parameter int TAG_W     = 5,
  parameter int DEPTH     = 8,
  parameter int MAX_LAT   = fpu_pkg::MAX_LAT,
  parameter int LAT [NUM_UNITS] = fpu_pkg::LAT_DEFAULT
) (
  input  logic                         mem_clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_UNITS-1:0]         in_op,
  input  logic [TAG_W-1:0]             in_tag,
  output logic [NUM_UNITS-1:0]         unit_start,
  input  logic [NUM_UNITS*WIDTH-1:0]   unit_y,
  input  logic [NUM_UNITS-1:0]         unit_ovf,
  input  logic [NUM_UNITS-1:0]         unit_unf,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_y,
  output logic [TAG_W-1:0]             out_tag,
  output logic [$clog2(NUM_UNITS)-1:0] out_unit,
  output logic                         out_ovf,
  output logic                         out_unf,
  output logic                         err_illegal,
  output logic                         busy
);

  import fpu_pkg::*;

  localparam int UW = $clog2(NUM_UNITS);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [UW-1:0] unit;
    logic [TAG_W-1:0] tag;
  } slot_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [TAG_W-1:0] tag;
    logic [UW-1:0]    unit;
    logic             ovf;
    logic             unf;
  } entry_t;

  // rsv[1] is the writeback slot; an entry in rsv[k] completes in k cycles.
  slot_t  rsv   [1:MAX_LAT];
  slot_t  rsv_n [1:MAX_LAT];
  entry_t wb;
  entry_t head;

  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic legal, credit, conflict, accept, accept_legal, push;

  // Credit counts both in-flight and buffered results so every writeback is
  // guaranteed a buffer slot. A new op lands in slot LAT[u] after the shift,
  // which is slot LAT[u]+1 before it; a unit with MAX_LAT latency can never
  // collide because nothing sits above the top slot.
  always_comb begin
    legal    = $onehot(in_op);
    credit   = ((CW+1)'(inflight) + (CW+1)'(count)) < (CW+1)'(DEPTH);
    conflict = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      for (int s = 2; s <= MAX_LAT; s++) begin
        if (in_op[u] && (LAT[u] + 1 == s) && rsv[s].valid) conflict = 1'b1;
      end
    end
    in_ready     = rstn && credit && (!legal || !conflict);
    accept       = in_valid && in_ready;
    accept_legal = accept && legal;
    unit_start   = accept_legal ? in_op : '0;
  end

  always_comb begin
    for (int s = 1; s < MAX_LAT; s++) rsv_n[s] = rsv[s + 1];
    rsv_n[MAX_LAT] = '0;
    for (int s = 1; s <= MAX_LAT; s++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (accept_legal && in_op[u] && (LAT[u] == s)) begin
          rsv_n[s].valid = 1'b1;
          rsv_n[s].unit  = UW'(u);
          rsv_n[s].tag   = in_tag;
        end
      end
    end
  end

  // Writeback mux: the unit named by the writeback slot is sampled this edge.
  always_comb begin
    wb      = '0;
    wb.tag  = rsv[1].tag;
    wb.unit = rsv[1].unit;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (rsv[1].unit == UW'(u)) begin
        wb.y   = unit_y[u*WIDTH +: WIDTH];
        wb.ovf = unit_ovf[u];
        wb.unf = unit_unf[u];
      end
    end
    push = rsv[1].valid;
  end

  always_ff @(posedge mem_clk) begin
    if (!rstn) begin
      for (int s = 1; s <= MAX_LAT; s++) rsv[s] <= '0;
      inflight    <= '0;
      err_illegal <= 1'b0;
    end else begin
      for (int s = 1; s <= MAX_LAT; s++) rsv[s] <= rsv_n[s];
      err_illegal <= accept && !legal;
      case ({accept_legal, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  fpu_result_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (mem_clk),
    .rstn  (rstn),
    .push  (push),
    .data  (wb),
    .ready (out_ready),
    .valid (out_valid),
    .head  (head),
    .count (count)
  );

  assign out_y    = head.y;
  assign out_tag  = head.tag;
  assign out_unit = head.unit;
  assign out_ovf  = head.ovf;
  assign out_unf  = head.unf;
  assign busy     = (inflight != '0) || (count != '0);

endmodule
